branch_resolve: RTL and testbench
=================================

# branch_resolve

Two-stage pipelined branch resolution unit for the execute stage, with XLEN-parametrised operands. It evaluates the branch condition, computes the correct next PC and the link address, and compares them against the fetch-stage prediction to raise a mispredict. It sits between issue and the front-end redirect logic, with valid/ready handshakes on both sides and a flush input.

## Interface
- XLEN, 32, operand/PC width (≥ 8)
- TAG_W, 4, opaque instruction tag width, passed through unchanged
- STAT_W, 16, statistics counter width (used only with the stats macro)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  kill all in-flight entries
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_rs1, in_rs2  in  XLEN  operands
- in_pc, in_imm  in  XLEN  instruction PC, sign-extended immediate
- in_op  in  branch_resolve_op_t  {branch_cond, unsigned_cmp, is_jump, is_jalr}
- in_pred_taken  in  1  predicted direction
- in_pred_target  in  XLEN  predicted target
- in_tag  in  TAG_W  tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_taken  out  1  resolved direction
- out_next_pc  out  XLEN  correct next PC
- out_link  out  XLEN  in_pc + 4
- out_mispredict  out  1  the predicted next PC differs from out_next_pc
- out_misalign  out  1  out_taken && out_next_pc[1]
- out_tag  out  TAG_W  tag
- stat_branches, stat_mispredicts  out  STAT_W  counters (with the macro only)

## Operation
- **S1** registers the accepted request.
- **S1→S2** evaluates the condition and computes the targets, then registers them.
- **Condition evaluation:**
  - EQ/NE use full-width equality.
  - LT/GE use signed compare, or unsigned compare when unsigned_cmp is set.
  - If is_jump is set, taken = 1 regardless of branch_cond.
  - Any other branch_cond value gives taken = 0.
- **Target computation:**
  - Branch or JAL target = pc + imm.
  - JALR target = (rs1 + imm) with bit 0 cleared.
  - All sums wrap modulo 2^XLEN.
- **Next PC:** out_next_pc = taken ? target : pc + 4.
- **Mispredict:** pred_next = pred_taken ? pred_target : pc + 4, and out_mispredict = (pred_next != out_next_pc).
- **Handshake:**
  - s2_adv = !s2_valid || out_ready.
  - in_ready = !flush && (!s1_valid || s2_adv).
  - Outputs hold stable while out_valid && !out_ready.
- **Flush:**
  - s1_valid and s2_valid are cleared at the next edge.
  - A request presented during flush is not accepted, because in_ready = 0.
  - Flushed entries never produce out_valid.
- **Reset values:**
  - s1_valid = 0, s2_valid = 0, so out_valid = 0 and in_ready = 1 after reset.
  - All data outputs are 0.
  - Counters are 0.
- **Reset mid-operation:** in-flight entries are discarded immediately (asynchronous reset).
- **Flush with out_valid && out_ready in the same cycle:** the handshake completes and counts as delivered.

## Timing
- **Latency:** 2 cycles from the accepting edge to out_valid when out_ready is held high.
- **Throughput:** 1 per cycle.
- **Backpressure:** out_ready low stalls S2. S1 then fills, and in_ready drops in the same cycle as the stall (combinational path from out_ready).
- **Combinational paths:** none from in_* to out_*. in_ready depends combinationally only on flush, out_ready and internal state.

## Configuration
- **With BRANCH_RESOLVE_STATS_EN defined:**
  - stat_branches increments on every output handshake.
  - stat_mispredicts increments on handshakes with out_mispredict = 1.
  - Both counters saturate at 2^STAT_W − 1 and do not wrap.
  - Flush does not clear them; only rst_n does.
- **Without it:** the ports and counters are absent.

## Structure
- **branch_resolve_pkg:**
  - branch_cond_t encodings (EQ, NE, LT, GE).
  - branch_resolve_op_t.
  - Constant INSN_BYTES = 4.
- **Sub-module branch_compare_xlen** (parametrised XLEN, combinational):
  - Inputs: rs1, rs2, branch_cond, unsigned_cmp.
  - Output: taken.
  - Instantiated once between S1 and S2.

## Test plan
- **Signed vs unsigned LT:** rs1=0xFFFFFFFF, rs2=1.
  - Signed LT → taken=1.
  - Unsigned LT → taken=0.
  - Predicted not-taken on the signed case → mispredict=1, next_pc=pc+imm.
- **JALR:** rs1=0x1001, imm=2, is_jalr → next_pc=0x1002, link=pc+4, misalign=1.
- **Wrap-around:** pc=0xFFFFFFFC, untaken branch → next_pc=0x0.
- **Back-to-back:** 4 back-to-back requests with out_ready=1 → 4 results on consecutive cycles starting 2 cycles after the first accept, tags in order.
- **Backpressure then flush:** out_ready low for 3 cycles → in_ready drops once S1 fills, outputs held constant. Then flush → out_valid=0 next cycle, no flushed tag ever emitted.
- **Stats, with BRANCH_RESOLVE_STATS_EN and STAT_W=2:** 5 mispredicting handshakes → stat_mispredicts saturates at 3; asserting rst_n low mid-run → all counters and out_valid are 0 immediately.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// ============================================================================
// branch_resolve_pkg : shared types and constants for the branch resolution unit
// Rev 1.0
// ============================================================================
`default_nettype none

package branch_resolve_pkg;

  // RISC-V funct3-style codes; the unsigned variants are selected by unsigned_cmp
  typedef enum logic [2:0] {
    BR_EQ = 3'd0,
    BR_NE = 3'd1,
    BR_LT = 3'd4,
    BR_GE = 3'd5
  } branch_cond_t;

  typedef struct packed {
    branch_cond_t branch_cond;
    logic         unsigned_cmp;
    logic         is_jump;
    logic         is_jalr;
  } branch_resolve_op_t;

  localparam int unsigned INSN_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/branch_resolve_compare.sv
// ============================================================================
// branch_compare_xlen : combinational branch condition evaluator
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_compare_xlen
  import branch_resolve_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  branch_cond_t    branch_cond,
  input  logic            unsigned_cmp,
  output logic            taken
);

  logic w_eq;
  logic w_lt;

  assign w_eq = (rs1 == rs2);
  assign w_lt = unsigned_cmp ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

  // Unassigned encodings resolve to not-taken
  always_comb begin
    taken = 1'b0;
    case (branch_cond)
      BR_EQ:   taken = w_eq;
      BR_NE:   taken = !w_eq;
      BR_LT:   taken = w_lt;
      BR_GE:   taken = !w_lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolve.sv
// ============================================================================
// branch_resolve : two-stage branch resolution with mispredict detection;
//                  optional handshake statistics under BRANCH_RESOLVE_STATS_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int STAT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_imm,
  input  branch_resolve_op_t in_op,
  input  logic               in_pred_taken,
  input  logic [XLEN-1:0]    in_pred_target,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_taken,
  output logic [XLEN-1:0]    out_next_pc,
  output logic [XLEN-1:0]    out_link,
  output logic               out_mispredict,
  output logic               out_misalign,
  output logic [TAG_W-1:0]   out_tag
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_branches,
  output logic [STAT_W-1:0]  stat_mispredicts
`endif
);

  localparam logic [XLEN-1:0] c_insn_bytes = XLEN'(INSN_BYTES);
  localparam logic [XLEN-1:0] c_jalr_mask  = {{(XLEN-1){1'b1}}, 1'b0};

  if (XLEN < 8 || STAT_W < 1) begin : g_param_check
    $error("branch_resolve: XLEN must be >= 8 and STAT_W >= 1");
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_s2_adv;
  logic w_accept;
  logic r_s1_valid;
  logic r_s2_valid;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !flush && (!r_s1_valid || w_s2_adv);
  assign w_accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // S1: captured request
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]    r_s1_rs1;
  logic [XLEN-1:0]    r_s1_rs2;
  logic [XLEN-1:0]    r_s1_pc;
  logic [XLEN-1:0]    r_s1_imm;
  branch_resolve_op_t r_s1_op;
  logic               r_s1_pred_taken;
  logic [XLEN-1:0]    r_s1_pred_target;
  logic [TAG_W-1:0]   r_s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid       <= 1'b0;
      r_s1_rs1         <= '0;
      r_s1_rs2         <= '0;
      r_s1_pc          <= '0;
      r_s1_imm         <= '0;
      r_s1_op          <= '0;
      r_s1_pred_taken  <= 1'b0;
      r_s1_pred_target <= '0;
      r_s1_tag         <= '0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_accept) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_accept) begin
        r_s1_rs1         <= in_rs1;
        r_s1_rs2         <= in_rs2;
        r_s1_pc          <= in_pc;
        r_s1_imm         <= in_imm;
        r_s1_op          <= in_op;
        r_s1_pred_taken  <= in_pred_taken;
        r_s1_pred_target <= in_pred_target;
        r_s1_tag         <= in_tag;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S1 -> S2: condition, targets, mispredict
  // --------------------------------------------------------------------------
  logic            w_cmp_taken;
  logic            w_taken;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_jalr_target;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_pred_next;
  logic            w_mispredict;
  logic            w_misalign;

  branch_compare_xlen #(
    .XLEN (XLEN)
  ) u_compare (
    .rs1          (r_s1_rs1),
    .rs2          (r_s1_rs2),
    .branch_cond  (r_s1_op.branch_cond),
    .unsigned_cmp (r_s1_op.unsigned_cmp),
    .taken        (w_cmp_taken)
  );

  assign w_taken       = r_s1_op.is_jump || w_cmp_taken;
  assign w_seq_pc      = r_s1_pc + c_insn_bytes;
  assign w_br_target   = r_s1_pc + r_s1_imm;
  assign w_jalr_target = (r_s1_rs1 + r_s1_imm) & c_jalr_mask;
  assign w_target      = r_s1_op.is_jalr ? w_jalr_target : w_br_target;
  assign w_next_pc     = w_taken ? w_target : w_seq_pc;
  assign w_pred_next   = r_s1_pred_taken ? r_s1_pred_target : w_seq_pc;
  assign w_mispredict  = (w_pred_next != w_next_pc);
  assign w_misalign    = w_taken && w_next_pc[1];

  // --------------------------------------------------------------------------
  // S2: result register, held while the consumer stalls
  // --------------------------------------------------------------------------
  logic             r_s2_taken;
  logic [XLEN-1:0]  r_s2_next_pc;
  logic [XLEN-1:0]  r_s2_link;
  logic             r_s2_mispredict;
  logic             r_s2_misalign;
  logic [TAG_W-1:0] r_s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid      <= 1'b0;
      r_s2_taken      <= 1'b0;
      r_s2_next_pc    <= '0;
      r_s2_link       <= '0;
      r_s2_mispredict <= 1'b0;
      r_s2_misalign   <= 1'b0;
      r_s2_tag        <= '0;
    end else begin
      if (flush) begin
        r_s2_valid <= 1'b0;
      end else if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (!flush && w_s2_adv && r_s1_valid) begin
        r_s2_taken      <= w_taken;
        r_s2_next_pc    <= w_next_pc;
        r_s2_link       <= w_seq_pc;
        r_s2_mispredict <= w_mispredict;
        r_s2_misalign   <= w_misalign;
        r_s2_tag        <= r_s1_tag;
      end
    end
  end

  assign out_valid      = r_s2_valid;
  assign out_taken      = r_s2_taken;
  assign out_next_pc    = r_s2_next_pc;
  assign out_link       = r_s2_link;
  assign out_mispredict = r_s2_mispredict;
  assign out_misalign   = r_s2_misalign;
  assign out_tag        = r_s2_tag;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef BRANCH_RESOLVE_STATS_EN
  logic              w_out_fire;
  logic [STAT_W-1:0] r_stat_branches;
  logic [STAT_W-1:0] r_stat_mispredicts;

  // A handshake in a flush cycle still counts as delivered
  assign w_out_fire = r_s2_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_out_fire) begin
      if (r_stat_branches != '1) begin
        r_stat_branches <= r_stat_branches + 1'b1;
      end
      if (r_s2_mispredict && (r_stat_mispredicts != '1)) begin
        r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
      end
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  // Counters compiled out; the statistics ports do not exist in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// ============================================================================
// tb_branch_resolve : scoreboard bench with a behavioural reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int XLEN   = 32;
  localparam int TAG_W  = 4;
  localparam int STAT_W = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [XLEN-1:0]    in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
  branch_resolve_op_t in_op = '0;
  logic               in_pred_taken = 1'b0;
  logic [XLEN-1:0]    in_pred_target = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_taken;
  logic [XLEN-1:0]    out_next_pc, out_link;
  logic               out_mispredict, out_misalign;
  logic [TAG_W-1:0]   out_tag;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [STAT_W-1:0]  stat_branches, stat_mispredicts;
`endif

  branch_resolve #(.XLEN(XLEN), .TAG_W(TAG_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_op(in_op), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_next_pc(out_next_pc), .out_link(out_link),
    .out_mispredict(out_mispredict), .out_misalign(out_misalign), .out_tag(out_tag)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             taken;
    logic [XLEN-1:0]  next_pc;
    logic [XLEN-1:0]  link;
    logic             mis;
    logic             misal;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
    int               del_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t log_q[$];
  int   stat_hs = 0;
  int   stat_mp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: straight from the instruction semantics
  function automatic exp_t ref_model(input logic [XLEN-1:0] rs1, rs2, pc, imm,
                                     input branch_resolve_op_t op, input logic pt,
                                     input logic [XLEN-1:0] ptgt, input logic [TAG_W-1:0] tag);
    exp_t e;
    logic [XLEN-1:0] tgt, seq, pred, one;
    one = 1;
    case (op.branch_cond)
      BR_EQ:   e.taken = (rs1 == rs2);
      BR_NE:   e.taken = (rs1 != rs2);
      BR_LT:   e.taken = op.unsigned_cmp ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
      BR_GE:   e.taken = op.unsigned_cmp ? (rs1 >= rs2) : ($signed(rs1) >= $signed(rs2));
      default: e.taken = 1'b0;
    endcase
    if (op.is_jump) e.taken = 1'b1;
    seq = pc + 4;
    if (op.is_jalr) tgt = (rs1 + imm) & ~one;
    else            tgt = pc + imm;
    e.next_pc = e.taken ? tgt : seq;
    pred      = pt ? ptgt : seq;
    e.mis     = (pred != e.next_pc);
    e.misal   = e.taken && e.next_pc[1];
    e.link    = seq;
    e.tag     = tag;
    e.acc_cyc = 0;
    e.del_cyc = 0;
    return e;
  endfunction

  function automatic int sat(input int v);
    int mx;
    mx = (1 << STAT_W) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic branch_resolve_op_t mk_op(input logic [2:0] c, input logic u, j, jr);
    branch_resolve_op_t o;
    o.branch_cond  = branch_cond_t'(c);
    o.unsigned_cmp = u;
    o.is_jump      = j;
    o.is_jalr      = jr;
    return o;
  endfunction

  // Monitor / scoreboard: everything sampled on the falling edge
  initial begin
    exp_t e;
    logic             hold_v;
    logic [TAG_W-1:0] hold_tag;
    logic [XLEN-1:0]  hold_pc;
    hold_v = 1'b0;
    hold_tag = '0;
    hold_pc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        hold_v  = 1'b0;
        stat_hs = 0;
        stat_mp = 0;
      end else begin
`ifdef BRANCH_RESOLVE_STATS_EN
        check("stat_branches", 64'(stat_branches), 64'(sat(stat_hs)));
        check("stat_mispredicts", 64'(stat_mispredicts), 64'(sat(stat_mp)));
`endif
        if (flush)               check("in_ready_flush", 64'(in_ready), 64'(0));
        else if (sb.size() < 2)  check("in_ready_free", 64'(in_ready), 64'(1));
        else                     check("in_ready_full", 64'(in_ready), 64'(out_ready));
        if (sb.size() == 0) check("idle_out_valid", 64'(out_valid), 64'(0));
        if (hold_v) begin
          check("hold_valid", 64'(out_valid), 64'(1));
          check("hold_tag", 64'(out_tag), 64'(hold_tag));
          check("hold_next_pc", 64'(out_next_pc), 64'(hold_pc));
        end
        hold_v   = out_valid && !out_ready && !flush;
        hold_tag = out_tag;
        hold_pc  = out_next_pc;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 64'(out_valid), 64'(0));
          end else begin
            e = sb.pop_front();
            check("out_tag", 64'(out_tag), 64'(e.tag));
            check("out_taken", 64'(out_taken), 64'(e.taken));
            check("out_next_pc", 64'(out_next_pc), 64'(e.next_pc));
            check("out_link", 64'(out_link), 64'(e.link));
            check("out_mispredict", 64'(out_mispredict), 64'(e.mis));
            check("out_misalign", 64'(out_misalign), 64'(e.misal));
            check("latency_min", 64'(cyc - e.acc_cyc >= 2), 64'(1));
            e.del_cyc = cyc;
            log_q.push_back(e);
            stat_hs++;
            if (e.mis) stat_mp++;
          end
        end
        if (flush) sb.delete();
        if (in_valid && in_ready) begin
          e = ref_model(in_rs1, in_rs2, in_pc, in_imm, in_op, in_pred_taken, in_pred_target, in_tag);
          e.acc_cyc = cyc;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic set_in(input logic [XLEN-1:0] rs1, rs2, pc, imm, input branch_resolve_op_t op,
                        input logic pt, input logic [XLEN-1:0] ptgt, input logic [TAG_W-1:0] tag);
    in_rs1 = rs1; in_rs2 = rs2; in_pc = pc; in_imm = imm; in_op = op;
    in_pred_taken = pt; in_pred_target = ptgt; in_tag = tag;
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [XLEN-1:0] rs1, rs2, pc, imm, input branch_resolve_op_t op,
                       input logic pt, input logic [XLEN-1:0] ptgt, input logic [TAG_W-1:0] tag);
    logic acc;
    int   n;
    set_in(rs1, rs2, pc, imm, op, pt, ptgt, tag);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    check("issue_accept", 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] rs1, rs2, pc, imm, ptgt, tmp;
    branch_resolve_op_t op;
    exp_t e;
    int flushed;

    // Reset state (asynchronous: visible while rst_n is low)
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_next_pc", 64'(out_next_pc), 64'(0));
    check("rst_link", 64'(out_link), 64'(0));
    check("rst_tag", 64'(out_tag), 64'(0));
    check("rst_flags", 64'({out_taken, out_mispredict, out_misalign}), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef BRANCH_RESOLVE_STATS_EN
    // Five mispredicting branches saturate a 2-bit counter at 3
    for (int i = 0; i < 5; i++)
      issue(32'd7, 32'd7, 32'h400, 32'h20, mk_op(3'd0, 1'b0, 1'b0, 1'b0), 1'b0, '0, TAG_W'(i));
    drain();
    @(negedge clk);
    check("stat_mp_sat", 64'(stat_mispredicts), 64'(3));
    check("stat_br_sat", 64'(stat_branches), 64'(3));
    @(posedge clk); #1;
`endif

    // Directed semantics: signed/unsigned LT, JALR, PC wrap
    log_q.delete();
    issue(32'hFFFF_FFFF, 32'd1, 32'h100, 32'h40, mk_op(3'd4, 1'b0, 1'b0, 1'b0), 1'b0, '0, 4'd1);
    issue(32'hFFFF_FFFF, 32'd1, 32'h100, 32'h40, mk_op(3'd4, 1'b1, 1'b0, 1'b0), 1'b0, '0, 4'd2);
    issue(32'h1001, 32'd0, 32'h2000, 32'd2, mk_op(3'd0, 1'b0, 1'b1, 1'b1), 1'b1, 32'h1002, 4'd3);
    issue(32'd5, 32'd5, 32'hFFFF_FFFC, 32'h80, mk_op(3'd1, 1'b0, 1'b0, 1'b0), 1'b0, '0, 4'd4);
    drain();
    check("dir_count", 64'(log_q.size()), 64'(4));
    if (log_q.size() == 4) begin
      check("slt_taken", 64'(log_q[0].taken), 64'(1));
      check("slt_next_pc", 64'(log_q[0].next_pc), 64'h140);
      check("slt_mispredict", 64'(log_q[0].mis), 64'(1));
      check("ult_taken", 64'(log_q[1].taken), 64'(0));
      check("jalr_next_pc", 64'(log_q[2].next_pc), 64'h1002);
      check("jalr_link", 64'(log_q[2].link), 64'h2004);
      check("jalr_misalign", 64'(log_q[2].misal), 64'(1));
      check("wrap_next_pc", 64'(log_q[3].next_pc), 64'h0);
    end

    // Back-to-back: consecutive results, two cycles after each accept, in order
    log_q.delete();
    for (int i = 0; i < 4; i++)
      issue(32'd1, 32'd2, 32'h3000, 32'h10, mk_op(3'd1, 1'b0, 1'b0, 1'b0), 1'b1, 32'h3010, TAG_W'(8 + i));
    drain();
    check("b2b_count", 64'(log_q.size()), 64'(4));
    for (int i = 0; i < log_q.size(); i++) begin
      check("b2b_tag", 64'(log_q[i].tag), 64'(8 + i));
      check("b2b_latency", 64'(log_q[i].del_cyc - log_q[i].acc_cyc), 64'(2));
      check("b2b_consecutive", 64'(log_q[i].del_cyc - log_q[0].del_cyc), 64'(i));
    end

    // Backpressure then flush
    log_q.delete();
    out_ready = 1'b0;
    issue(32'd1, 32'd1, 32'h500, 32'h8, mk_op(3'd0, 1'b0, 1'b0, 1'b0), 1'b1, 32'h508, 4'hA);
    issue(32'd1, 32'd2, 32'h600, 32'h8, mk_op(3'd0, 1'b0, 1'b0, 1'b0), 1'b0, '0, 4'hB);
    set_in(32'd3, 32'd3, 32'h700, 32'h8, mk_op(3'd0, 1'b0, 1'b0, 1'b0), 1'b0, '0, 4'hC);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_tag_held", 64'(out_tag), 64'hA);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    flushed = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i].tag inside {4'hA, 4'hB, 4'hC}) flushed++;
    check("flushed_tags_emitted", 64'(flushed), 64'(0));

    // Randomised traffic with backpressure and occasional flush
    for (int c = 0; c < 400; c++) begin
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      tmp = $urandom;
      imm = {{20{tmp[11]}}, tmp[11:0]};
      pc  = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(0, 9))
        0, 1:    op = mk_op(3'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        2, 3:    op = mk_op(3'd1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        4, 5:    op = mk_op(3'd4, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        6, 7:    op = mk_op(3'd5, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        8:       op = mk_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        default: op = mk_op(3'($urandom_range(0, 7)), 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      endcase
      e    = ref_model(rs1, rs2, pc, imm, op, 1'b0, '0, '0);
      ptgt = ($urandom_range(0, 1) == 1) ? e.next_pc : $urandom;
      set_in(rs1, rs2, pc, imm, op, 1'($urandom_range(0, 1)), ptgt, TAG_W'($urandom));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 3);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with an entry held in S2
    out_ready = 1'b0;
    issue(32'd9, 32'd9, 32'h800, 32'h4, mk_op(3'd0, 1'b0, 1'b0, 1'b0), 1'b0, '0, 4'h5);
    @(posedge clk); #1;
    @(negedge clk);
    check("prereset_out_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_tag", 64'(out_tag), 64'(0));
`ifdef BRANCH_RESOLVE_STATS_EN
    check("midrst_stat_br", 64'(stat_branches), 64'(0));
    check("midrst_stat_mp", 64'(stat_mispredicts), 64'(0));
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
